bus_frame_receiver: RTL and testbench

- Per-node receive stage that sits directly downstream of the shared serial bus driven by the 16-node FPGA transmitter (the `bus_show` line).
- Deserializes one frame at a time: start bit, source address, receiver address, 64-bit data, 4-bit CRC, stop bit.
- Filters frames on address, recomputes and checks the CRC, then hands accepted payloads to the node's local logic.
- The payload is held in a single-entry output buffer with a valid/ready handshake.

---
 rtl/bus_frame_receiver.sv | 213 +++++++++++++++++++++
 tb/tb_bus_frame_receiver.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/bus_frame_receiver.sv
// bus_frame_receiver: per-node deserializer for the shared serial frame bus.
// It receives one frame at a time:
//   start(1) | src(ADDR_W) | dst(ADDR_W) | data(DATA_W) | crc(CRC_W) | stop(1)
// Each field is sent MSB first. A frame is accepted when its destination is
// MY_ADDR or the broadcast address, and its CRC (x^4+x+1) checks. Accepted
// frames go into a single-entry valid/ready output buffer.
//
// Ports:
//   clock     - system clock, rising edge
//   reset_n   - synchronous active-low reset
//   bus_in    - serial bus line, idle 0
//   rx_ready  - consumer accepts the buffered frame when high with rx_valid
//   rx_valid  - output buffer holds an unconsumed frame
//   rx_data   - payload of the buffered frame
//   rx_src    - source address of the buffered frame
//   crc_err   - one-cycle pulse: addressed frame failed its CRC check
//   frame_err - one-cycle pulse: stop bit sampled as 1
//   overrun   - one-cycle pulse: good frame dropped, buffer full
//   busy      - FSM is not in IDLE
module bus_frame_receiver #(
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned ADDR_W  = 4,
  parameter int unsigned CRC_W   = 4,
  parameter logic [ADDR_W-1:0] MY_ADDR = ADDR_W'(1)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              bus_in,
  input  logic              rx_ready,
  output logic              rx_valid,
  output logic [DATA_W-1:0] rx_data,
  output logic [ADDR_W-1:0] rx_src,
  output logic              crc_err,
  output logic              frame_err,
  output logic              overrun,
  output logic              busy
);

  localparam int unsigned CNT_W = 7;
  localparam logic [CRC_W-1:0]  CRC_POLY   = CRC_W'(4'b0011);
  localparam logic [ADDR_W-1:0] BCAST_ADDR = '1;
  localparam logic [CNT_W-1:0]  ADDR_LAST  = CNT_W'(ADDR_W - 1);
  localparam logic [CNT_W-1:0]  DATA_LAST  = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0]  CRC_LAST   = CNT_W'(CRC_W - 1);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SRC  = 3'd1,
    ST_DST  = 3'd2,
    ST_DATA = 3'd3,
    ST_CRC  = 3'd4,
    ST_STOP = 3'd5
  } state_t;

  state_t              state_q,     state_d;
  logic [CNT_W-1:0]    cnt_q,       cnt_d;
  logic [ADDR_W-1:0]   src_q,       src_d;
  logic [ADDR_W-1:0]   dst_q,       dst_d;
  logic [DATA_W-1:0]   data_q,      data_d;
  logic [CRC_W-1:0]    crc_q,       crc_d;
  logic [CRC_W-1:0]    rcrc_q,      rcrc_d;
  logic                rx_valid_q,  rx_valid_d;
  logic [DATA_W-1:0]   rx_data_q,   rx_data_d;
  logic [ADDR_W-1:0]   rx_src_q,    rx_src_d;
  logic                crc_err_q,   crc_err_d;
  logic                frame_err_q, frame_err_d;
  logic                overrun_q,   overrun_d;
  logic                busy_q,      busy_d;

  logic                crc_fb;
  logic [CRC_W-1:0]    crc_next;
  logic                addr_hit;
  logic                buf_free;

  // Next-state, datapath and registered-output logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    src_d       = src_q;
    dst_d       = dst_q;
    data_d      = data_q;
    crc_d       = crc_q;
    rcrc_d      = rcrc_q;
    rx_valid_d  = rx_valid_q & ~rx_ready;
    rx_data_d   = rx_data_q;
    rx_src_d    = rx_src_q;
    crc_err_d   = 1'b0;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;

    crc_fb   = crc_q[CRC_W-1] ^ bus_in;
    crc_next = {crc_q[CRC_W-2:0], 1'b0} ^ (crc_fb ? CRC_POLY : '0);
    addr_hit = (dst_q == MY_ADDR) || (dst_q == BCAST_ADDR);
    // A same-cycle accept frees the buffer for a new load
    buf_free = ~rx_valid_q | rx_ready;

    case (state_q)
      ST_IDLE: begin
        if (bus_in) begin
          state_d = ST_SRC;
          cnt_d   = '0;
          crc_d   = '0;
        end
      end
      ST_SRC: begin
        src_d = {src_q[ADDR_W-2:0], bus_in};
        crc_d = crc_next;
        if (cnt_q == ADDR_LAST) begin
          state_d = ST_DST;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DST: begin
        dst_d = {dst_q[ADDR_W-2:0], bus_in};
        crc_d = crc_next;
        if (cnt_q == ADDR_LAST) begin
          state_d = ST_DATA;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DATA: begin
        data_d = {data_q[DATA_W-2:0], bus_in};
        crc_d  = crc_next;
        if (cnt_q == DATA_LAST) begin
          state_d = ST_CRC;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_CRC: begin
        rcrc_d = {rcrc_q[CRC_W-2:0], bus_in};
        if (cnt_q == CRC_LAST) begin
          state_d = ST_STOP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_STOP: begin
        state_d = ST_IDLE;
        // Priority: framing, then address filter, then CRC, then buffer
        if (bus_in) begin
          frame_err_d = 1'b1;
        end else if (!addr_hit) begin
          // not for this node: drop silently
        end else if (rcrc_q != crc_q) begin
          crc_err_d = 1'b1;
        end else if (buf_free) begin
          rx_valid_d = 1'b1;
          rx_data_d  = data_q;
          rx_src_d   = src_q;
        end else begin
          overrun_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      src_q       <= '0;
      dst_q       <= '0;
      data_q      <= '0;
      crc_q       <= '0;
      rcrc_q      <= '0;
      rx_valid_q  <= 1'b0;
      rx_data_q   <= '0;
      rx_src_q    <= '0;
      crc_err_q   <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      src_q       <= src_d;
      dst_q       <= dst_d;
      data_q      <= data_d;
      crc_q       <= crc_d;
      rcrc_q      <= rcrc_d;
      rx_valid_q  <= rx_valid_d;
      rx_data_q   <= rx_data_d;
      rx_src_q    <= rx_src_d;
      crc_err_q   <= crc_err_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      busy_q      <= busy_d;
    end
  end

  assign rx_valid  = rx_valid_q;
  assign rx_data   = rx_data_q;
  assign rx_src    = rx_src_q;
  assign crc_err   = crc_err_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_bus_frame_receiver.sv
// Directed self-checking bench for bus_frame_receiver.
// Bus bits and rx_ready are driven on the falling edge, and outputs are
// sampled on the falling edge.
module tb_bus_frame_receiver;

  localparam int unsigned DATA_W = 64;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned FLEN   = 78;

  logic              clock;
  logic              reset_n;
  logic              bus_in;
  logic              rx_ready;
  logic              rx_valid;
  logic [DATA_W-1:0] rx_data;
  logic [ADDR_W-1:0] rx_src;
  logic              crc_err;
  logic              frame_err;
  logic              overrun;
  logic              busy;

  int checks   = 0;
  int failures = 0;

  bus_frame_receiver #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .CRC_W  (4),
    .MY_ADDR(4'd1)
  ) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .bus_in   (bus_in),
    .rx_ready (rx_ready),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .rx_src   (rx_src),
    .crc_err  (crc_err),
    .frame_err(frame_err),
    .overrun  (overrun),
    .busy     (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference CRC x^4+x+1 over src, dst, data, MSB first, init 0
  function automatic logic [3:0] ref_crc(input logic [3:0] s, input logic [3:0] d,
                                         input logic [63:0] p);
    logic [71:0] bits;
    logic [3:0]  c;
    logic        fb;
    bits = {s, d, p};
    c = 4'h0;
    for (int i = 71; i >= 0; i--) begin
      fb = c[3] ^ bits[i];
      c  = {c[2:0], 1'b0} ^ (fb ? 4'b0011 : 4'b0000);
    end
    return c;
  endfunction

  function automatic logic [FLEN-1:0] make_frame(input logic [3:0] s, input logic [3:0] d,
                                                 input logic [63:0] p, input logic [3:0] c,
                                                 input logic stop);
    return {1'b1, s, d, p, c, stop};
  endfunction

  // Call at a falling edge; returns at the falling edge after the stop bit is sampled
  task automatic send_frame(input logic [FLEN-1:0] f, input bit accept_at_stop);
    for (int i = FLEN - 1; i >= 0; i--) begin
      bus_in = f[i];
      if (i == 0 && accept_at_stop) rx_ready = 1'b1;
      @(negedge clock);
      if (i == 40) check("busy_mid_frame", 64'(busy), 64'd1);
    end
    bus_in = 1'b0;
    if (accept_at_stop) rx_ready = 1'b0;
  endtask

  task automatic consume();
    rx_ready = 1'b1;
    @(negedge clock);
    rx_ready = 1'b0;
    check("rx_valid_after_accept", 64'(rx_valid), 64'd0);
  endtask

  logic [FLEN-1:0] frm;
  logic [63:0]     pay_a, pay_b, pay_c;

  initial begin
    reset_n  = 1'b0;
    bus_in   = 1'b0;
    rx_ready = 1'b0;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;

    // Reset state
    check("reset_rx_valid", 64'(rx_valid), 64'd0);
    check("reset_rx_data", rx_data, 64'd0);
    check("reset_rx_src", 64'(rx_src), 64'd0);
    check("reset_pulses", 64'({crc_err, frame_err, overrun}), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);

    // Idle line
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      check("idle_quiet", 64'({busy, rx_valid, crc_err, frame_err, overrun}), 64'd0);
    end

    // Good frame, hand-computed CRC 4'h5
    send_frame(make_frame(4'h0, 4'h1, 64'h0, 4'h5, 1'b0), 1'b0);
    check("good_rx_valid", 64'(rx_valid), 64'd1);
    check("good_rx_src", 64'(rx_src), 64'd0);
    check("good_rx_data", rx_data, 64'd0);
    check("good_no_pulse", 64'({crc_err, frame_err, overrun}), 64'd0);
    check("good_busy_low", 64'(busy), 64'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check("hold_rx_valid", 64'(rx_valid), 64'd1);
      check("hold_rx_data", rx_data, 64'd0);
    end
    consume();

    // Bad CRC
    send_frame(make_frame(4'h0, 4'h1, 64'h0, 4'h4, 1'b0), 1'b0);
    check("crc_err_pulse", 64'(crc_err), 64'd1);
    check("crc_err_no_valid", 64'(rx_valid), 64'd0);
    @(negedge clock);
    check("crc_err_one_cycle", 64'(crc_err), 64'd0);

    // Other node's address: silent drop
    send_frame(make_frame(4'h0, 4'h2, 64'h0, ref_crc(4'h0, 4'h2, 64'h0), 1'b0), 1'b0);
    check("foreign_quiet", 64'({rx_valid, crc_err, frame_err, overrun}), 64'd0);
    @(negedge clock);
    check("foreign_quiet2", 64'({rx_valid, crc_err, frame_err, overrun}), 64'd0);

    // Broadcast accepted
    send_frame(make_frame(4'h0, 4'hF, 64'h0, ref_crc(4'h0, 4'hF, 64'h0), 1'b0), 1'b0);
    check("bcast_rx_valid", 64'(rx_valid), 64'd1);
    check("bcast_rx_data", rx_data, 64'd0);
    consume();

    // Stop bit error, then a back-to-back good frame
    pay_a = 64'hDEAD_BEEF_0123_4567;
    send_frame(make_frame(4'h0, 4'h1, 64'h0, 4'h5, 1'b1), 1'b0);
    check("frame_err_pulse", 64'(frame_err), 64'd1);
    check("frame_err_only", 64'({rx_valid, crc_err, overrun}), 64'd0);
    send_frame(make_frame(4'h3, 4'h1, pay_a, ref_crc(4'h3, 4'h1, pay_a), 1'b0), 1'b0);
    check("after_ferr_valid", 64'(rx_valid), 64'd1);
    check("after_ferr_src", 64'(rx_src), 64'd3);
    check("after_ferr_data", rx_data, pay_a);
    check("after_ferr_no_pulse", 64'({crc_err, frame_err, overrun}), 64'd0);
    consume();

    // Two good frames back-to-back with rx_ready low: overrun on the second
    pay_a = 64'hA5A5_0000_FFFF_1234;
    pay_b = 64'h0F0F_1111_2222_3333;
    send_frame(make_frame(4'h5, 4'h1, pay_a, ref_crc(4'h5, 4'h1, pay_a), 1'b0), 1'b0);
    check("b2b_first_valid", 64'(rx_valid), 64'd1);
    check("b2b_first_data", rx_data, pay_a);
    send_frame(make_frame(4'h6, 4'hF, pay_b, ref_crc(4'h6, 4'hF, pay_b), 1'b0), 1'b0);
    check("overrun_pulse", 64'(overrun), 64'd1);
    check("overrun_keeps_data", rx_data, pay_a);
    check("overrun_keeps_src", 64'(rx_src), 64'd5);
    @(negedge clock);
    check("overrun_one_cycle", 64'(overrun), 64'd0);

    // Accept in the stop cycle of a new good frame: new data loads, valid stays
    pay_c = 64'h1234_5678_9ABC_DEF0;
    send_frame(make_frame(4'h7, 4'h1, pay_c, ref_crc(4'h7, 4'h1, pay_c), 1'b0), 1'b1);
    check("swap_rx_valid", 64'(rx_valid), 64'd1);
    check("swap_rx_data", rx_data, pay_c);
    check("swap_rx_src", 64'(rx_src), 64'd7);
    check("swap_no_overrun", 64'(overrun), 64'd0);
    consume();

    // Reset at bit 40 of a good frame
    frm = make_frame(4'h2, 4'h1, 64'hFFFF_0000_FFFF_0000, ref_crc(4'h2, 4'h1, 64'hFFFF_0000_FFFF_0000), 1'b0);
    for (int i = FLEN - 1; i >= FLEN - 40; i--) begin
      bus_in = frm[i];
      @(negedge clock);
    end
    reset_n = 1'b0;
    bus_in  = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    check("midreset_busy", 64'(busy), 64'd0);
    for (int i = 0; i < 80; i++) begin
      @(negedge clock);
      check("midreset_quiet", 64'({busy, rx_valid, crc_err, frame_err, overrun}), 64'd0);
    end
    send_frame(make_frame(4'h2, 4'h1, 64'h1, ref_crc(4'h2, 4'h1, 64'h1), 1'b0), 1'b0);
    check("fresh_rx_valid", 64'(rx_valid), 64'd1);
    check("fresh_rx_data", rx_data, 64'h1);
    check("fresh_rx_src", 64'(rx_src), 64'd2);
    consume();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
